// File: rtl/riscv_boot_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
// The loader side uses the slave modport; the program source / memory side uses master.
interface riscv_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/riscv_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs little-endian words into
// instruction memory and holds the core in reset until the whole program is loaded.
module riscv_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    riscv_boot_loader_if.slave  bus,
    input  logic                reload,
    output logic                core_reset,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // Capacity and comparisons are done in 17 bits so a full 16-bit length and
    // 2**ADDR_WIDTH words can both be represented without wrap-around.
    localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WORD_ONE = (ADDR_WIDTH+1)'(1);

    state_t                state_q;
    state_t                state_d;

    logic [15:0]           len_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [23:0]           word_q;

    logic                  accept;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   word_cnt_inc;
    logic                  last_word;

    logic                  imem_we_d;
    logic                  core_reset_d;
    logic                  done_d;
    logic                  err_d;

    assign accept       = bus.rx_valid && bus.rx_ready;
    assign len_full     = {bus.rx_data, len_q[7:0]};
    assign word_cnt_inc = word_cnt_q + WORD_ONE;
    assign last_word    = (17'(word_cnt_inc) == {1'b0, len_q});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            ST_LEN_LO: begin
                if (accept) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && byte_cnt_q == 2'd3) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = last_word ? ST_DONE : ST_DATA;
            end
            ST_DONE, ST_ERR: begin
                if (reload) state_d = ST_LEN_LO;
            end
            default: state_d = ST_LEN_LO;
        endcase
    end

    // Output decode: rx_ready follows the current state; the status outputs and the
    // write strobe are derived from the next state so their registers line up with it.
    always_comb begin
        bus.rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_DATA);
        imem_we_d    = (state_d == ST_WRITE);
        core_reset_d = (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q          <= '0;
            byte_cnt_q     <= '0;
            word_cnt_q     <= '0;
            word_q         <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset     <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= imem_we_d;
            core_reset  <= core_reset_d;
            done        <= done_d;
            err         <= err_d;

            unique case (state_q)
                ST_LEN_LO: begin
                    if (accept) len_q[7:0] <= bus.rx_data;
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= bus.rx_data;
                        byte_cnt_q  <= '0;
                        word_cnt_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= bus.rx_data;
                            2'd1: word_q[15:8]  <= bus.rx_data;
                            2'd2: word_q[23:16] <= bus.rx_data;
                            default: begin
                                // The final byte goes straight into the write word.
                                bus.imem_addr  <= word_cnt_q[ADDR_WIDTH-1:0];
                                bus.imem_wdata <= {bus.rx_data, word_q};
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    word_cnt_q <= word_cnt_inc;
                end
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        len_q      <= '0;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        word_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
